// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master between NREQ requesters.
// Each grant loads m_din, pulses m_st, follows m_busy and returns rx_dat with a done pulse.
module spi_arbiter #(
  parameter int WIDTH   = 13,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] tx_dat,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic [WIDTH-1:0]      rx_dat,
  output logic                  busy,
  output logic                  m_st,
  output logic [WIDTH-1:0]      m_din,
  input  logic [WIDTH-1:0]      m_dout,
  input  logic                  m_busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, START, WAIT, XFER, FIN} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     last, cur, sel, idx;
  logic              sel_vld;
  logic [NREQ-1:0]   sel_oh;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  tx_arr [NREQ];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      tx_arr[i] = tx_dat[i*WIDTH +: WIDTH];
    end
  end

  // First requesting index after the last winner, wrapping modulo NREQ.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = IW'((32'(last) + off) % NREQ);
      if (!sel_vld && req[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
  end

  // The counter holds cycles-minus-one, so this compare is the cycle it reaches TIMEOUT-1.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_vld) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (m_busy) state_nxt = XFER;
               else if (cnt == CW'(TIMEOUT - 2)) state_nxt = FIN;
      XFER:    if (!m_busy) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      last   <= IW'(NREQ - 1);
      cur    <= '0;
      cnt    <= '0;
      gnt    <= '0;
      done   <= '0;
      err    <= 1'b0;
      rx_dat <= '0;
      busy   <= 1'b0;
      m_st   <= 1'b0;
      m_din  <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      m_st  <= 1'b0;
      done  <= '0;
      err   <= 1'b0;
      case (state)
        IDLE: if (sel_vld) begin
          gnt   <= sel_oh;
          cur   <= sel;
          m_din <= tx_arr[sel];
          m_st  <= 1'b1;
        end
        START: cnt <= '0;
        WAIT: if (!m_busy) begin
          cnt <= cnt + 1'b1;
          if (state_nxt == FIN) begin
            done <= gnt;
            err  <= 1'b1;
          end
        end
        XFER: if (!m_busy) begin
          rx_dat <= m_dout;
          done   <= gnt;
        end
        FIN: begin
          gnt  <= '0;
          last <= cur;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares one spi_master between NREQ independent requesters.
- Each requester raises a level request with its transmit word. The arbiter picks one requester in round-robin order and loads the master's din. It then issues the st pulse, tracks the master's busy window and returns the received word with a one-cycle done pulse.
- Sits between client logic (switch/button handlers, display refresh, test pattern generators) and spi_master.
- Replaces the direct ce1s_n_ms-to-st connection with sequenced, shared access.

Parameters:
- WIDTH, 13, SPI word width; must match spi_master WIDTH.
- NREQ, 4, number of requesters (1..8).
- TIMEOUT, 1024, max clk cycles from m_st to m_busy rising before the transaction is aborted.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- req  input  NREQ  level request per requester.
- tx_dat  input  NREQ*WIDTH  transmit words; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant; held for the whole transaction.
- done  output  NREQ  one-cycle completion pulse to the granted requester.
- err  output  1  one-cycle pulse, coincident with done, when the transaction timed out.
- rx_dat  output  WIDTH  registered received word; valid from the done cycle until the next done.
- busy  output  1  high in every state except IDLE.
- m_st  output  1  one-cycle start pulse to spi_master st.
- m_din  output  WIDTH  transmit word to spi_master din.
- m_dout  input  WIDTH  received word from spi_master dout.
- m_busy  input  1  high while spi_master is shifting.

Behaviour:
- Reset (rst=0, asynchronous):
  - state IDLE; gnt, done, err, m_st all 0; rx_dat and m_din 0; timeout counter 0.
  - last-granted pointer = NREQ-1, so requester 0 wins first.
- All outputs are registered.
- States: IDLE, START, WAIT, XFER, FIN.
- IDLE:
  - If any req bit is set, select the first set index scanning last+1, last+2, ... mod NREQ.
  - On that edge: set gnt one-hot, latch the tx_dat slice into m_din, go to START.
  - req is sampled only in IDLE.
- START:
  - m_st=1 for exactly this one cycle; clear timeout counter; go to WAIT.
  - m_din is stable from START until IDLE.
- WAIT:
  - Counter increments each cycle.
  - m_busy=1 → go to XFER.
  - Counter reaches TIMEOUT-1 with m_busy still 0 → go to FIN with the error flag set.
  - m_busy=1 and the timeout on the same cycle → m_busy wins.
- XFER:
  - Wait for m_busy=0.
  - Then capture m_dout into rx_dat on that edge and go to FIN with the error flag clear.
  - No timeout in XFER; duration is bounded by the master.
- FIN (one cycle):
  - done[g]=1 for the granted index g; err = error flag.
  - last=g; gnt cleared at the end of FIN; go to IDLE.
  - On timeout, rx_dat is not updated and keeps its previous value.
- Latency:
  - req sampled at edge k → gnt visible after k, m_st high in cycle k+1.
  - Minimum request-to-done with ideal busy: 4 cycles + master busy time.
- Back-to-back: after FIN there is at least one IDLE cycle before the next START.
- Requester obligations:
  - Drop req in the cycle after done, or it is re-arbitrated.
  - A requester holding req continuously still yields to the others via round-robin.
- req dropped mid-transaction: ignored; the transaction completes and done still pulses.
- req raised by another requester mid-transaction: queued implicitly (level), served after FIN per round-robin.
- rst asserted mid-transaction: immediate return to reset values; no done or err pulse.
  - The master may still be shifting; the next grant waits in WAIT, since m_busy must rise after the new m_st.
- m_busy already high at START (stale): treated as a rise.
- NREQ=1: degenerates to a sequencer; gnt[0] toggles per transaction.

Test Plan:
- Single request: req=4'b0001, tx_dat[12:0]=13'h1dad, master loopback returns 13'h0ced → m_st one pulse, m_din=13'h1dad, then done=4'b0001 and rx_dat=13'h0ced, err=0.
- Round-robin: req=4'b1111 held, data 13'h0001..13'h0004 → grant order 0,1,2,3,0, each with exactly one m_st; no requester is granted twice before all others.
- Timeout: m_busy tied 0, TIMEOUT=16 → done pulse 16 cycles after m_st, err=1, rx_dat unchanged from the prior value 13'h0ced.
- Mid-transaction changes: req0 drops during XFER and req2 rises → done[0] still pulses, then gnt=4'b0100 after one IDLE cycle.
- Reset mid-XFER: rst=0 for 2 cycles → gnt, done, err, m_st immediately 0; after release, req=4'b0010 is granted first-served correctly with last pointer reset (order from 0).
- Busy edge cases: busy and timeout on the same cycle → XFER taken, err=0; stale m_busy=1 at START → goes straight to XFER.
